// File: rtl/wavelet_bank_sched.sv
// Time-multiplexed scheduler: one shared signed MAC sweeps an NUM_ELEM-deep sample window
// for each filter of a runtime-loadable coefficient bank. Optional macro: WAVELET_SAT_EN.
module wavelet_bank_sched #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 7,
  parameter int NUM_FILTERS   = 4,
  parameter int OUT_BITS      = 16,
  localparam int NUM_COEF = NUM_FILTERS * NUM_ELEM,
  localparam int ADDR_W   = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1,
  localparam int FIDX_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int TAP_W    = $clog2(NUM_ELEM)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [BITS_PER_ELEM-1:0] i_sample,
  input  logic                            i_sample_valid,
  output logic                            o_sample_ready,
  input  logic                            i_coef_we,
  input  logic [ADDR_W-1:0]               i_coef_addr,
  input  logic signed [BITS_PER_ELEM-1:0] i_coef_data,
  output logic signed [OUT_BITS-1:0]      o_sum,
  output logic [FIDX_W-1:0]               o_filter_idx,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_busy
);
  localparam int PROD_W = 2 * BITS_PER_ELEM;
  localparam int ACC_W  = PROD_W + $clog2(NUM_ELEM) + 1;
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(NUM_ELEM - 1);
  localparam logic [FIDX_W-1:0] FILT_LAST = FIDX_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_e;

  state_e                          state_q;
  logic signed [BITS_PER_ELEM-1:0] win_q  [NUM_ELEM];
  logic signed [BITS_PER_ELEM-1:0] coef_q [NUM_COEF];
  logic [FIDX_W-1:0]               filter_q;
  logic [TAP_W-1:0]                tap_q;
  logic signed [ACC_W-1:0]         acc_q;
  logic signed [OUT_BITS-1:0]      sum_q;
  logic [FIDX_W-1:0]               fidx_q;
  logic                            ready_q;
  logic                            valid_q;
  logic                            busy_q;

  logic [ADDR_W-1:0]               coef_idx;
  logic signed [BITS_PER_ELEM-1:0] coef_sel;
  logic signed [BITS_PER_ELEM-1:0] win_sel;
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_W-1:0]         acc_d;
  logic signed [OUT_BITS-1:0]      sum_d;
  logic                            coef_wr_ok;

  assign coef_idx   = ADDR_W'(int'(filter_q) * NUM_ELEM + int'(tap_q));
  assign coef_sel   = coef_q[coef_idx];
  assign win_sel    = win_q[tap_q];
  assign prod       = PROD_W'(coef_sel) * PROD_W'(win_sel);
  assign acc_d      = acc_q + ACC_W'(prod);
  assign coef_wr_ok = i_coef_we && (int'(i_coef_addr) < NUM_COEF);

`ifdef WAVELET_SAT_EN
  if (OUT_BITS < ACC_W) begin : g_sat
    // Bits above the output sign position must all agree with it, otherwise clamp.
    logic [ACC_W-OUT_BITS:0] top_bits;
    assign top_bits = acc_d[ACC_W-1:OUT_BITS-1];
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      sum_d = acc_d[OUT_BITS-1:0];
      if (!(&top_bits) && (|top_bits)) begin
        sum_d = acc_d[ACC_W-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                               : {1'b0, {(OUT_BITS-1){1'b1}}};
      end
    end
  end else begin : g_ext
    assign sum_d = OUT_BITS'(acc_d);
  end
`else
  assign sum_d = OUT_BITS'(acc_d);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values of the others (the window shift relies on this).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      filter_q <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      fidx_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      // NOTE: window and coefficient storage are reset explicitly, so they are built
      // from flops rather than a RAM macro.
      for (int k = 0; k < NUM_ELEM; k++) win_q[k] <= '0;
      for (int k = 0; k < NUM_COEF; k++) coef_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (coef_wr_ok) coef_q[i_coef_addr] <= i_coef_data;
          if (i_sample_valid) begin
            for (int k = NUM_ELEM - 1; k > 0; k--) win_q[k] <= win_q[k-1];
            win_q[0] <= i_sample;
            filter_q <= '0;
            tap_q    <= '0;
            acc_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (tap_q == TAP_LAST) begin
            sum_q   <= sum_d;
            fidx_q  <= filter_q;
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            if (filter_q == FILT_LAST) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              filter_q <= filter_q + 1'b1;
              tap_q    <= '0;
              acc_q    <= '0;
              state_q  <= S_MAC;
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_sample_ready = ready_q;
  assign o_valid        = valid_q;
  assign o_busy         = busy_q;
  assign o_sum          = sum_q;
  assign o_filter_idx   = fidx_q;

endmodule

// File: tb/tb_wavelet_bank_sched.sv
// Scoreboard bench for wavelet_bank_sched: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_wavelet_bank_sched;
  localparam int BPE = 8;
  localparam int OB  = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic signed [BPE-1:0] i_sample = '0;
  logic                  i_sample_valid = 1'b0;
  logic                  o_sample_ready;
  logic                  i_coef_we = 1'b0;
  logic [4:0]            i_coef_addr = '0;
  logic signed [BPE-1:0] i_coef_data = '0;
  logic signed [OB-1:0]  o_sum;
  logic [1:0]            o_filter_idx;
  logic                  o_valid;
  logic                  i_ready = 1'b1;
  logic                  o_busy;

  wavelet_bank_sched dut (
    .clk(clk), .reset(reset),
    .i_sample(i_sample), .i_sample_valid(i_sample_valid), .o_sample_ready(o_sample_ready),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_sum(o_sum), .o_filter_idx(o_filter_idx), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OB-1:0] sum;
    logic [1:0]           idx;
  } exp_t;

  exp_t sb_q[$];
  int   acc_cycles[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired before the expected DUT event", name);
  endtask

  task automatic push_exp(input int s, input int idx);
    exp_t e;
    e.sum = OB'(s);
    e.idx = 2'(idx);
    sb_q.push_back(e);
  endtask

  // Result monitor: a handshake completes on the posedge following this negedge.
  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got sum %0d idx %0d, expected no output", o_sum, o_filter_idx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_sum", o_sum, e.sum);
        check("result_idx", o_filter_idx, e.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && o_sample_ready && i_sample_valid) acc_cycles.push_back(cyc);
  end

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!o_sample_ready && guard < 300);
    if (!o_sample_ready) fail_now("wait_idle");
  endtask

  task automatic wait_valid();
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!o_valid && guard < 300);
    if (!o_valid) fail_now("wait_valid");
  endtask

  task automatic send_sample(input int s);
    wait_idle();
    i_sample = BPE'(s);
    i_sample_valid = 1'b1;
    @(posedge clk); #1;
    i_sample_valid = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int d);
    i_coef_we   = 1'b1;
    i_coef_addr = 5'(addr);
    i_coef_data = BPE'(d);
    @(posedge clk); #1;
    i_coef_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wrap_tbl[7];
    int sat_tbl[7];
    wrap_tbl = '{16384, -32768, -16384, 0, 16384, -32768, -16384};
    sat_tbl  = '{16384, 32767, 32767, 32767, 32767, 32767, 32767};

    // Reset values
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", o_sample_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_sum", o_sum, 0);
    check("rst_idx", o_filter_idx, 0);

    // Single tap coefficient: only filter 0 sees the sample; first valid 8 edges after accept
    write_coef(0, 1);
    push_exp(5, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 50);
    check("latency", n, 8);

    // Filter 0 all ones: running window sums; back-to-back period 33
    wait_idle();
    do_reset();
    for (int t = 0; t < 7; t++) write_coef(t, 1);
    acc_cycles.delete();
    push_exp(1, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    push_exp(3, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    push_exp(6, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(1);
    send_sample(2);
    send_sample(3);
    if (acc_cycles.size() >= 3) begin
      check("period_1", acc_cycles[1] - acc_cycles[0], 33);
      check("period_2", acc_cycles[2] - acc_cycles[1], 33);
    end else begin
      fail_now("period_accepts");
    end

    // Reset in the middle of filter 1's MAC: window 9,3,2,1 gives filter-0 result 15
    push_exp(15, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(9);
    wait_valid();
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midrst_valid", o_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", o_sample_ready, 1);
    check("midrst_sum", o_sum, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < 7; t++) write_coef(t, 1);
    push_exp(4, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(4);

    // Backpressure: hold EMIT 10 cycles with a sample offered that must be ignored
    wait_idle();
    i_ready = 1'b0;
    push_exp(6, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(2);
    wait_valid();
    i_sample = 8'sd100;
    i_sample_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_sum", o_sum, 6);
      check("stall_idx", o_filter_idx, 0);
      check("stall_valid", o_valid, 1);
      check("stall_ready", o_sample_ready, 0);
    end
    i_sample_valid = 1'b0;
    i_ready = 1'b1;
    push_exp(7, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(1);

    // Write landing with acceptance (addr 7 = filter 1 tap 0), write during MAC ignored
    push_exp(10, 0); push_exp(6, 1); push_exp(0, 2); push_exp(0, 3);
    wait_idle();
    i_sample = 8'sd3;
    i_sample_valid = 1'b1;
    i_coef_we = 1'b1;
    i_coef_addr = 5'd7;
    i_coef_data = 8'sd2;
    @(posedge clk); #1;
    i_sample_valid = 1'b0;
    i_coef_addr = 5'd0;
    i_coef_data = 8'sd50;
    @(posedge clk); #1;
    i_coef_we = 1'b0;
    wait_idle();
    write_coef(28, 77);
    push_exp(10, 0); push_exp(0, 1); push_exp(0, 2); push_exp(0, 3);
    send_sample(0);

    // Extreme values: every product +16384, window fills one -128 per sample
    wait_idle();
    do_reset();
    for (int a = 0; a < 28; a++) write_coef(a, -128);
    for (int k = 0; k < 7; k++) begin
      for (int f = 0; f < 4; f++) begin
`ifdef WAVELET_SAT_EN
        push_exp(sat_tbl[k], f);
`else
        push_exp(wrap_tbl[k], f);
`endif
      end
    end
    for (int k = 0; k < 7; k++) send_sample(-128);

    wait_idle();
    repeat (2) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
